// File: rtl/hp1349a_bus_tx.sv
// hp1349a_bus_tx: transmitter side of the HP 1349A LDAV/LRFD four-phase display bus.
// Define HP1349A_TX_FIFO_EN for a 2**FIFO_AW word FIFO; otherwise a single holding register.
module hp1349a_bus_tx #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_data,
    input  logic        err_clr,
    output logic        BUS_LDAV,
    input  logic        BUS_LRFD,
    output logic [14:0] BUS_DATA,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] sent_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RFD,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [7:0]  SETUP_LD = 8'(SETUP_CYC);
    localparam logic [7:0]  HOLD_LD  = 8'(HOLD_CYC);
    localparam logic [16:0] TMO_LIM  = 17'(TIMEOUT_CYC);

    state_t      state, state_d;
    logic [1:0]  lrfd_sync;
    logic        lrfd_s;
    logic        ready_en;
    logic        wr_en;
    logic        pop;
    logic        fifo_empty;
    logic [14:0] head_data;
    logic [7:0]  cnt, cnt_d;
    logic [15:0] tcnt, tcnt_d;
    logic        ldav_d;
    logic [14:0] data_d;
    logic [15:0] sent_d;
    logic        err_d;
    logic        unused_bit0;

    // LRFD idles "not ready" through reset so nothing launches before it is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrfd_sync <= 2'b11;
            ready_en  <= 1'b0;
        end else begin
            lrfd_sync <= {lrfd_sync[0], BUS_LRFD};
            ready_en  <= 1'b1;
        end
    end

    assign lrfd_s      = lrfd_sync[1];
    assign wr_en       = in_valid && in_ready;
    assign unused_bit0 = head_data[0];

`ifdef HP1349A_TX_FIFO_EN
    localparam int unsigned       DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE = 1;

    logic [14:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    // count never exceeds DEPTH, so its MSB alone marks full.
    assign fifo_empty = (count == '0);
    assign in_ready   = ready_en && !count[FIFO_AW];
    assign head_data  = mem[rd_ptr];
`else
    logic [14:0] hold_reg;
    logic        hold_valid;
    logic        unused_aw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
        end else if (wr_en) begin
            hold_reg   <= in_data;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign fifo_empty = !hold_valid;
    assign in_ready   = ready_en && !hold_valid;
    assign head_data  = hold_reg;
    assign unused_aw  = ^FIFO_AW;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tcnt_d  = tcnt;
        ldav_d  = BUS_LDAV;
        data_d  = BUS_DATA;
        sent_d  = sent_cnt;
        err_d   = timeout_err && !err_clr;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty)
                    state_d = WAIT_RFD;
            end
            WAIT_RFD: begin
                if (!lrfd_s) begin
                    pop     = 1'b1;
                    data_d  = {head_data[14:1], 1'b0};
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // The edge that takes the counter to zero is the one that drops LDAV.
                if (cnt <= 8'd1) begin
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    ldav_d  = 1'b0;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (tcnt != '1)
                    tcnt_d = tcnt + 16'd1;
                if (lrfd_s) begin
                    ldav_d  = 1'b1;
                    sent_d  = sent_cnt + 16'd1;
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else if ((TMO_LIM != '0) && (({1'b0, tcnt} + 17'd1) == TMO_LIM)) begin
                    ldav_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt <= 8'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            BUS_LDAV    <= 1'b1;
            BUS_DATA    <= '0;
            sent_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            tcnt        <= tcnt_d;
            BUS_LDAV    <= ldav_d;
            BUS_DATA    <= data_d;
            sent_cnt    <= sent_d;
            timeout_err <= err_d;
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_hp1349a_bus_tx.sv
// Bench for hp1349a_bus_tx: table-driven single words plus burst, timeout, not-ready and reset sequences.
module tb_hp1349a_bus_tx;

    localparam int unsigned SETUP_CYC   = 4;
    localparam int unsigned HOLD_CYC    = 2;
    localparam int unsigned TIMEOUT_CYC = 100;
`ifdef HP1349A_TX_FIFO_EN
    localparam int CAP        = 16;
    localparam int HOLD_WORDS = 3;
`else
    localparam int CAP        = 1;
    localparam int HOLD_WORDS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_data = '0;
    logic        err_clr = 1'b0;
    logic        BUS_LDAV;
    logic        BUS_LRFD;
    logic [14:0] BUS_DATA;
    logic        busy;
    logic        timeout_err;
    logic [15:0] sent_cnt;

    hp1349a_bus_tx #(
        .SETUP_CYC  (SETUP_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .FIFO_AW    (4),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .err_clr    (err_clr),
        .BUS_LDAV   (BUS_LDAV),
        .BUS_LRFD   (BUS_LRFD),
        .BUS_DATA   (BUS_DATA),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sent_cnt   (sent_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [14:0] exp_q[$];

    bit rx_force_high = 1'b0;
    bit rx_respond    = 1'b1;
    int rx_delay      = 3;
    int rx_phase      = 0;
    int rx_wait       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Receiver model: sole driver of LRFD; checks each word against the scoreboard when LDAV falls.
    initial begin
        logic        ldav_prev;
        logic [14:0] prev_data;
        logic [14:0] hold_data;
        logic [14:0] e;
        int          stable;
        int          hold_wait;
        bit          fell;
        bit          rose;
        ldav_prev = 1'b1;
        prev_data = '0;
        hold_data = '0;
        stable    = 0;
        hold_wait = 0;
        BUS_LRFD  = 1'b0;
        forever begin
            @(negedge clk);
            fell = ldav_prev && !BUS_LDAV;
            rose = !ldav_prev && BUS_LDAV;
            if (BUS_DATA != prev_data)
                stable = 0;
            else
                stable++;
            prev_data = BUS_DATA;
            if (hold_wait > 0) begin
                hold_wait--;
                if (hold_wait == 0 && rst_n)
                    check("hold_data", BUS_DATA, hold_data);
            end
            if (rose) begin
                hold_wait = HOLD_CYC;
                hold_data = BUS_DATA;
            end
            if (fell) begin
                check("setup_stable", stable >= SETUP_CYC, 1);
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL unexpected_word: bus %0h with no word expected at %0t", BUS_DATA, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_word", BUS_DATA, e);
                end
            end
            if (rx_force_high) begin
                BUS_LRFD = 1'b1;
                rx_phase = 0;
            end else begin
                case (rx_phase)
                    0: begin
                        BUS_LRFD = 1'b0;
                        if (fell && rx_respond) begin
                            rx_phase = 1;
                            rx_wait  = rx_delay;
                        end
                    end
                    1: begin
                        rx_wait--;
                        if (rx_wait == 0) begin
                            BUS_LRFD = 1'b1;
                            rx_phase = 2;
                            rx_wait  = 2;
                        end
                    end
                    default: begin
                        rx_wait--;
                        if (rx_wait == 0) begin
                            BUS_LRFD = 1'b0;
                            rx_phase = 0;
                        end
                    end
                endcase
            end
            ldav_prev = BUS_LDAV;
        end
    end

    task automatic send(input logic [14:0] d, input logic [14:0] e, input int budget, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < budget; i++) begin
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || !BUS_LDAV || rx_phase != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", !(busy || !BUS_LDAV || rx_phase != 0), 1);
    endtask

    typedef struct {
        logic [14:0] din;
        logic [14:0] bus;
        logic [15:0] cnt;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        bit          ok;
        bit          seen;
        int          n;
        int          acc;
        logic [15:0] base;
        logic [14:0] d;

        vecs[0] = '{15'h7FFF, 15'h7FFE, 16'd2};
        vecs[1] = '{15'h0001, 15'h0000, 16'd3};
        vecs[2] = '{15'h1234, 15'h1234, 16'd4};
        vecs[3] = '{15'h4001, 15'h4000, 16'd5};
        vecs[4] = '{15'h5555, 15'h5554, 16'd6};

        // Reset asserted before any clock edge, with in_valid high.
        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        in_data  = 15'h7FFF;
        #2;
        check("rst_ldav", BUS_LDAV, 1);
        check("rst_data", BUS_DATA, 0);
        check("rst_ready", in_ready, 0);
        check("rst_sent", sent_cnt, 0);
        check("rst_err", timeout_err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1 check("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1 check("ready_first_edge", in_ready, 1);

        // Single word, ideal receiver: accept-to-LDAV latency.
        send(15'h2AAB, 15'h2AAA, 5, ok);
        check("single_accept", ok, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (BUS_LDAV && n < 50);
        check("ldav_latency", n, SETUP_CYC + 2);
        check("single_bus", BUS_DATA, 15'h2AAA);
        wait_idle(200);
        check("single_sent", sent_cnt, 1);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].din, vecs[i].bus, 10, ok);
            check("vec_accept", ok, 1);
            wait_idle(200);
            check("vec_sent", sent_cnt, vecs[i].cnt);
            check("vec_bus_idle", BUS_DATA, vecs[i].bus);
        end

        // Burst: fill with receiver not ready, then drain through a slow receiver.
        rx_force_high = 1'b1;
        repeat (4) @(negedge clk);
        base = sent_cnt;
        acc  = 0;
        for (int i = 0; i < 20; i++) begin
            d = 15'(16'h0101 + 16'(i * 7));
            send(d, d & 15'h7FFE, 4, ok);
            if (!ok)
                break;
            acc++;
        end
        check("burst_capacity", acc, CAP);
        check("burst_ready_low", in_ready, 0);
        check("burst_busy", busy, 1);
        rx_force_high = 1'b0;
        rx_delay      = 10;
        n = 0;
        for (int i = acc; i < 20; i++) begin
            d = 15'(16'h0101 + 16'(i * 7));
            send(d, d & 15'h7FFE, 400, ok);
            if (ok)
                n++;
        end
        check("burst_rest_accepted", n, 20 - acc);
        wait_idle(3000);
        check("burst_sent", sent_cnt, base + 16'd20);
        check("burst_queue_empty", exp_q.size(), 0);
        rx_delay = 3;

        // Receiver never answers: timeout drops the word.
        rx_respond = 1'b0;
        base = sent_cnt;
        send(15'h0F0F, 15'h0F0E, 10, ok);
        n = 0;
        while (BUS_LDAV && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_ldav_fell", BUS_LDAV, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!BUS_LDAV && n < 300);
        check("tmo_duration", n, TIMEOUT_CYC);
        check("tmo_err_set", timeout_err, 1);
        check("tmo_sent_same", sent_cnt, base);
        wait_idle(100);
        rx_respond = 1'b1;
        send(15'h3C3D, 15'h3C3C, 10, ok);
        wait_idle(200);
        check("tmo_next_sent", sent_cnt, base + 16'd1);
        check("tmo_err_sticky", timeout_err, 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("tmo_err_clear", timeout_err, 0);

        // LRFD held high: words wait, no strobe, busy stays up.
        rx_force_high = 1'b1;
        repeat (3) @(negedge clk);
        base = sent_cnt;
        acc  = 0;
        for (int i = 0; i < HOLD_WORDS; i++) begin
            d = 15'(16'h2200 + 16'(i * 3));
            send(d, d & 15'h7FFE, 10, ok);
            if (ok)
                acc++;
        end
        check("notrdy_accepted", acc, HOLD_WORDS);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!BUS_LDAV)
                seen = 1'b1;
        end
        check("notrdy_no_ldav", seen, 0);
        check("notrdy_busy", busy, 1);
        rx_force_high = 1'b0;
        wait_idle(500);
        check("notrdy_resumed", sent_cnt, base + 16'(HOLD_WORDS));

        // Reset pulsed during STROBE.
        rx_respond = 1'b0;
        send(15'h1111, 15'h1110, 10, ok);
        send(15'h2223, 15'h2222, 20, ok);
        check("rstmid_second_accept", ok, 1);
        n = 0;
        while (BUS_LDAV && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rstmid_in_strobe", BUS_LDAV, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ldav", BUS_LDAV, 1);
        check("rstmid_data", BUS_DATA, 0);
        check("rstmid_sent", sent_cnt, 0);
        check("rstmid_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_sent", sent_cnt, 0);
        check("post_rst_ready", in_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!BUS_LDAV || busy)
                seen = 1'b1;
        end
        check("post_rst_quiet", seen, 0);
        rx_respond = 1'b1;
        send(15'h0ABC, 15'h0ABC, 10, ok);
        wait_idle(200);
        check("post_rst_one_word", sent_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, check_cnt);
        $fatal(1);
    end

endmodule

// File: doc/hp1349a_bus_tx.md
# hp1349a_bus_tx

Transmitting end of the HP 1349A-style parallel display bus. The block accepts 15-bit display words from an internal valid/ready stream, buffers them, and drives them onto BUS_DATA with the LDAV/LRFD four-phase handshake. It is the instrument side, used to drive a display board or to loop back into the display receiver for bring-up. LRFD is sampled through a synchronizer, so the receiver may run on any clock.

## Interface
Parameters:
- SETUP_CYC, 4: clk cycles BUS_DATA is stable before LDAV asserts (1..255)
- HOLD_CYC, 2: clk cycles BUS_DATA is held after LDAV deasserts (1..255)
- FIFO_AW, 4: log2 FIFO depth (used only with HP1349A_TX_FIFO_EN)
- TIMEOUT_CYC, 50000: maximum STROBE duration in cycles; 0 disables the timeout

Ports:
- clk  in  1  system clock (clk25 domain)
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  15  display word; bit 0 is forced to 0 on the bus
- err_clr  in  1  one-cycle pulse that clears timeout_err
- BUS_LDAV  out  1  data-available strobe, active low
- BUS_LRFD  in  1  receiver ready-for-data, active low, asynchronous
- BUS_DATA  out  15  bus data
- busy  out  1  high when state != IDLE or the FIFO is not empty
- timeout_err  out  1  sticky flag, set when a word was dropped by the timeout
- sent_cnt  out  16  count of words completed by handshake (wraps)

## Operation
- Transfer: in_valid && in_ready at a rising edge writes in_data.
- LRFD passes through a 2-flop synchronizer, giving lrfd_s.
- States:
  - IDLE: if a word is queued, go to WAIT_RFD.
  - WAIT_RFD: when lrfd_s == 0, pop the word, load BUS_DATA = {word[14:1],1'b0}, load the counter with SETUP_CYC and go to SETUP.
  - SETUP: decrement the counter. At 0, set BUS_LDAV = 0 and go to STROBE.
  - STROBE: when lrfd_s == 1, set BUS_LDAV = 1, increment sent_cnt, load HOLD_CYC and go to HOLD. If the timeout counter reaches TIMEOUT_CYC first, set BUS_LDAV = 1, set timeout_err, leave sent_cnt unchanged and go to HOLD.
  - HOLD: decrement the counter. At 0, go to IDLE.
- BUS_DATA keeps its last value in IDLE; it changes only on entry to SETUP.
- The timeout counter is 16 bits. It clears on entry to STROBE and saturates.
- sent_cnt wraps from 16'hFFFF to 0.
- timeout_err: err_clr clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: BUS_LDAV = 1, BUS_DATA = 0, in_ready = 0, timeout_err = 0, sent_cnt = 0, busy = 0, state = IDLE, FIFO empty. These apply immediately on rst_n low; there is no clk dependency.
- in_ready rises on the first clk edge after rst_n deasserts.
- Reset asserted mid-transfer: LDAV releases asynchronously and queued words are discarded.
- LRFD input to lrfd_s latency: 2 clk.
- Data in to BUS_DATA change, with an empty FIFO and LRFD already low: accept at edge T, IDLE to WAIT_RFD at T+1, load at T+2, LDAV low at T+2+SETUP_CYC.
- LRFD must be low again at the start of every word. WAIT_RFD enforces this, so there are no back-to-back strobes without receiver re-arm.
- Minimum word period: 1 + 1 + SETUP_CYC + 2 + HOLD_CYC cycles, plus receiver response time.
- FIFO full: in_ready = 0. A write and a pop in the same cycle while full are not possible, because in_ready is computed from the registered count.
- FIFO empty: the block stays in IDLE and busy = 0.

## Configuration
- HP1349A_TX_FIFO_EN defined: a 2^FIFO_AW-entry FIFO. in_ready = !full.
- Not defined: a single holding register. in_ready = 1 only while the register is empty. The register empties on the pop in WAIT_RFD. FIFO_AW is ignored.

## Test plan
- Reset check: hold rst_n low with in_valid = 1 → BUS_LDAV = 1, BUS_DATA = 0, in_ready = 0, sent_cnt = 0, with no clk edge required.
- Single word, ideal receiver (LRFD low; pulses high 3 clk after LDAV falls, low again 2 clk later), in_data = 15'h2AAB:
  - BUS_DATA = 15'h2AAA, stable ≥ 4 clk before LDAV falls and ≥ 2 clk after it rises;
  - sent_cnt = 1.
- Burst of 20 words, FIFO_AW = 4, slow receiver: in_ready drops after 16 queued words. All 20 words appear on BUS_DATA in order and sent_cnt = 20.
- Receiver never raises LRFD, TIMEOUT_CYC = 100:
  - LDAV returns high exactly 100 clk after falling;
  - timeout_err = 1 and sent_cnt is unchanged;
  - the next word is still sent;
  - err_clr clears the flag.
- LRFD held high (not ready), 3 words queued: no LDAV activity and busy = 1. Drop LRFD → transfers resume.
- rst_n pulsed low during STROBE: LDAV goes high immediately. After reset release, the FIFO is empty, busy = 0, and sent_cnt = 0.
